// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single data-memory port between the instruction
// fetch unit (read-only) and the load/store unit (read/write). Requests are
// granted round-robin, and one transaction is in flight at a time.
// A memory that never answers is cut off after TIMEOUT cycles with an error response.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [AW-1:0] ifu_addr,
    output logic          ifu_rsp_valid,
    output logic [DW-1:0] ifu_rdata,
    output logic          ifu_rsp_err,

    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic [AW-1:0] lsu_addr,
    input  logic          lsu_wen,
    input  logic [2:0]    lsu_memop,
    input  logic [DW-1:0] lsu_wdata,
    output logic          lsu_rsp_valid,
    output logic [DW-1:0] lsu_rdata,
    output logic          lsu_rsp_err,

    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [2:0]    mem_op,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_rsp_valid,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    // The timeout counter is 8 bits wide, so the limit fits in 9 bits with headroom for the +1.
    localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);
    localparam logic [2:0] OP_WORD     = 3'b010;

    state_t        state;
    state_t        next_state;
    logic          owner;
    logic          last_grant;
    logic [AW-1:0] lat_addr;
    logic [2:0]    lat_op;
    logic [DW-1:0] lat_wdata;
    logic          lat_wen;
    logic [7:0]    wait_cnt;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          grant_ifu;
    logic          grant_lsu;
    logic          timeout_hit;

    // The last WAIT cycle is the one in which the counter is about to reach TIMEOUT.
    assign timeout_hit = ({1'b0, wait_cnt} + 9'd1) >= TIMEOUT_LIM;

    // Round-robin grant in IDLE: on a tie, the requester that did not go last wins.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state == IDLE) begin
            if (ifu_req_valid && (!lsu_req_valid || last_grant)) begin
                grant_ifu = 1'b1;
            end else if (lsu_req_valid) begin
                grant_lsu = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a response arriving with the accept skips WAIT.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (grant_ifu || grant_lsu) next_state = REQ;
            REQ:  if (mem_req_ready) next_state = mem_rsp_valid ? RESP : WAIT;
            WAIT: if (mem_rsp_valid || timeout_hit) next_state = RESP;
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Latch the granted request, count WAIT cycles and capture the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            lat_addr   <= '0;
            lat_op     <= '0;
            lat_wdata  <= '0;
            lat_wen    <= 1'b0;
            wait_cnt   <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ifu) begin
                        owner     <= 1'b0;
                        lat_addr  <= ifu_addr;
                        lat_op    <= OP_WORD;
                        lat_wdata <= '0;
                        lat_wen   <= 1'b0;
                    end else if (grant_lsu) begin
                        owner     <= 1'b1;
                        lat_addr  <= lsu_addr;
                        lat_op    <= lsu_memop;
                        lat_wdata <= lsu_wdata;
                        lat_wen   <= lsu_wen;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        wait_cnt <= '0;
                        if (mem_rsp_valid) begin
                            rsp_data <= lat_wen ? '0 : mem_rdata;
                            rsp_err  <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        rsp_data <= lat_wen ? '0 : mem_rdata;
                        rsp_err  <= 1'b0;
                    end else begin
                        if (wait_cnt != 8'hFF) begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                        if (timeout_hit) begin
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    last_grant <= owner;
                end
                default: begin
                end
            endcase
        end
    end

    // Drive handshakes, downstream request and responses; everything idles at zero.
    always_comb begin
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rdata     = '0;
        ifu_rsp_err   = 1'b0;
        lsu_rsp_valid = 1'b0;
        lsu_rdata     = '0;
        lsu_rsp_err   = 1'b0;
        mem_req_valid = 1'b0;
        mem_addr      = '0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        mem_op        = '0;
        mem_wdata     = '0;
        case (state)
            IDLE: begin
                ifu_req_ready = grant_ifu;
                lsu_req_ready = grant_lsu;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = lat_addr;
                mem_rd        = ~lat_wen;
                mem_wr        = lat_wen;
                mem_op        = lat_op;
                mem_wdata     = lat_wdata;
            end
            RESP: begin
                if (owner) begin
                    lsu_rsp_valid = 1'b1;
                    lsu_rdata     = rsp_data;
                    lsu_rsp_err   = rsp_err;
                end else begin
                    ifu_rsp_valid = 1'b1;
                    ifu_rdata     = rsp_data;
                    ifu_rsp_err   = rsp_err;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven and randomized checks of mem_arbiter with a
// short timeout, driving a scripted memory and a transaction-level reference.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk;
    logic          rst;
    logic          ifu_req_valid;
    logic          ifu_req_ready;
    logic [AW-1:0] ifu_addr;
    logic          ifu_rsp_valid;
    logic [DW-1:0] ifu_rdata;
    logic          ifu_rsp_err;
    logic          lsu_req_valid;
    logic          lsu_req_ready;
    logic [AW-1:0] lsu_addr;
    logic          lsu_wen;
    logic [2:0]    lsu_memop;
    logic [DW-1:0] lsu_wdata;
    logic          lsu_rsp_valid;
    logic [DW-1:0] lsu_rdata;
    logic          lsu_rsp_err;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [2:0]    mem_op;
    logic [DW-1:0] mem_wdata;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rdata;

    int checks;
    int errors;
    int model_last;

    // One transaction: requester inputs, memory behaviour and expected outcome.
    // lat < 0 means the memory never answers; lat = 0 answers with the accept.
    typedef struct {
        bit          ifu_v;
        bit          lsu_v;
        logic [31:0] ifu_a;
        logic [31:0] lsu_a;
        bit          wen;
        logic [2:0]  op;
        logic [31:0] wdata;
        int          stall;
        int          lat;
        logic [31:0] mdata;
        int          exp_owner;
        int          exp_cycle;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t tbl[8];

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .ifu_req_valid(ifu_req_valid),
        .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rdata(ifu_rdata),
        .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid),
        .lsu_req_ready(lsu_req_ready),
        .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen),
        .lsu_memop(lsu_memop),
        .lsu_wdata(lsu_wdata),
        .lsu_rsp_valid(lsu_rsp_valid),
        .lsu_rdata(lsu_rdata),
        .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .mem_wr(mem_wr),
        .mem_op(mem_op),
        .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string name);
        checkOutput(name,
            {ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
             lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
             mem_req_valid, mem_addr, mem_rd, mem_wr, mem_op, mem_wdata},
            160'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_last = 1;
    endtask

    // Reference: round-robin winner and completion time from the handshake rules.
    function automatic vec_t modelTxn(input vec_t v, input int last);
        vec_t r;
        int   w;
        r = v;
        if (v.ifu_v && v.lsu_v) w = (last == 1) ? 0 : 1;
        else                    w = v.lsu_v ? 1 : 0;
        r.exp_owner = w;
        if (v.lat < 0 || v.lat > TO) begin
            r.exp_cycle = 2 + v.stall + TO;
            r.exp_err   = 1'b1;
            r.exp_rdata = '0;
        end else begin
            r.exp_cycle = 2 + v.stall + v.lat;
            r.exp_err   = 1'b0;
            r.exp_rdata = (w == 1 && v.wen) ? 32'd0 : v.mdata;
        end
        return r;
    endfunction

    // Runs one transaction from the IDLE grant cycle (cycle 0) until one cycle after the response.
    task automatic applyStimulus(input string name, input vec_t v);
        int          stall_left;
        int          since;
        int          pulses;
        int          pulse_cyc;
        int          other;
        bit          accepted;
        logic [31:0] got_rdata;
        logic        got_err;
        logic [31:0] e_addr;
        logic        e_wr;
        logic [2:0]  e_op;
        logic        own_v;
        logic        oth_v;

        e_addr = (v.exp_owner == 1) ? v.lsu_a : v.ifu_a;
        e_wr   = (v.exp_owner == 1) ? v.wen : 1'b0;
        e_op   = (v.exp_owner == 1) ? v.op : 3'b010;

        ifu_req_valid = v.ifu_v;
        ifu_addr      = v.ifu_a;
        lsu_req_valid = v.lsu_v;
        lsu_addr      = v.lsu_a;
        lsu_wen       = v.wen;
        lsu_memop     = v.op;
        lsu_wdata     = v.wdata;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        #1;
        checkOutput({name, " grant"}, {ifu_req_ready, lsu_req_ready},
                    {v.exp_owner == 0, v.exp_owner == 1});
        @(posedge clk);
        @(negedge clk);

        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        ifu_addr      = $urandom;
        lsu_addr      = $urandom;
        lsu_wen       = 1'(($urandom));
        lsu_memop     = 3'($urandom);
        lsu_wdata     = $urandom;

        stall_left = v.stall;
        accepted   = 1'b0;
        since      = 0;
        pulses     = 0;
        pulse_cyc  = -1;
        other      = 0;
        got_rdata  = '0;
        got_err    = 1'b0;
        for (int c = 1; c <= v.exp_cycle + 1; c++) begin
            mem_rdata = $urandom;
            if (!accepted) begin
                mem_rsp_valid = 1'b0;
                if (mem_req_valid && stall_left == 0) begin
                    mem_req_ready = 1'b1;
                    accepted      = 1'b1;
                    if (v.lat == 0) begin
                        mem_rsp_valid = 1'b1;
                        mem_rdata     = v.mdata;
                    end
                end else begin
                    mem_req_ready = 1'b0;
                    if (mem_req_valid) stall_left--;
                end
            end else begin
                mem_req_ready = 1'b0;
                since++;
                mem_rsp_valid = (v.lat > 0 && since == v.lat);
                if (mem_rsp_valid) mem_rdata = v.mdata;
            end
            #1;
            checkOutput({name, " mem_req_valid"}, mem_req_valid, c <= 1 + v.stall);
            if (c <= 1 + v.stall) begin
                checkOutput({name, " mem_req_fields"}, {mem_addr, mem_rd, mem_wr, mem_op},
                            {e_addr, ~e_wr, e_wr, e_op});
                if (e_wr) checkOutput({name, " mem_wdata"}, mem_wdata, v.wdata);
            end
            own_v = (v.exp_owner == 1) ? lsu_rsp_valid : ifu_rsp_valid;
            oth_v = (v.exp_owner == 1) ? ifu_rsp_valid : lsu_rsp_valid;
            if (own_v) begin
                pulses++;
                pulse_cyc = c;
                got_rdata = (v.exp_owner == 1) ? lsu_rdata : ifu_rdata;
                got_err   = (v.exp_owner == 1) ? lsu_rsp_err : ifu_rsp_err;
            end
            if (oth_v) other++;
            @(posedge clk);
            @(negedge clk);
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        checkOutput({name, " rsp_pulses"}, pulses, 1);
        checkOutput({name, " rsp_cycle"}, pulse_cyc, v.exp_cycle);
        checkOutput({name, " rsp_rdata"}, got_rdata, v.exp_rdata);
        checkOutput({name, " rsp_err"}, got_err, v.exp_err);
        checkOutput({name, " other_rsp"}, other, 0);
        model_last = v.exp_owner;
    endtask

    initial begin
        logic [2:0] ops[5];
        vec_t       rv;

        ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        ifu_req_valid = 1'b0;
        ifu_addr      = '0;
        lsu_req_valid = 1'b0;
        lsu_addr      = '0;
        lsu_wen       = 1'b0;
        lsu_memop     = '0;
        lsu_wdata     = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;

        //            ifu lsu ifu_a         lsu_a         wen op      wdata  stl lat mdata         own cyc rdata         err
        tbl[0] = '{1'b1, 1'b0, 32'h80000000, 32'h0,        1'b0, 3'b000, 32'h0,    0,  1, 32'hDEADBEEF, 0, 3, 32'hDEADBEEF, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 32'h0,        32'h80000003, 1'b1, 3'b000, 32'hAB,   3,  1, 32'h12345678, 1, 6, 32'h0,        1'b0};
        tbl[2] = '{1'b0, 1'b1, 32'h0,        32'h100,      1'b0, 3'b010, 32'h0,    0, -1, 32'h9999,     1, 6, 32'h0,        1'b1};
        tbl[3] = '{1'b1, 1'b0, 32'h200,      32'h0,        1'b0, 3'b000, 32'h0,    0,  0, 32'hCAFEF00D, 0, 2, 32'hCAFEF00D, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 32'h204,      32'h300,      1'b0, 3'b101, 32'h0,    1,  2, 32'h0000BEEF, 1, 5, 32'h0000BEEF, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 32'h400,      32'h304,      1'b0, 3'b100, 32'h0,    0,  4, 32'h11112222, 0, 6, 32'h11112222, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 32'h0,        32'h308,      1'b0, 3'b001, 32'h0,    2,  6, 32'h55,       1, 8, 32'h0,        1'b1};
        tbl[7] = '{1'b0, 1'b1, 32'h0,        32'h30C,      1'b1, 3'b001, 32'h1234, 0,  0, 32'hFFFFFFFF, 1, 2, 32'h0,        1'b0};

        repeat (2) @(negedge clk);
        #1;
        checkAllZero("reset_state");
        rst        = 1'b0;
        model_last = 1;

        // Both requesters held valid with an instant memory: grants alternate IFU, LSU, IFU, LSU.
        for (int c = 0; c < 12; c++) begin
            ifu_req_valid = (c <= 9);
            lsu_req_valid = (c <= 9);
            ifu_addr      = 32'h1000 + c;
            lsu_addr      = 32'h2000 + c;
            lsu_wen       = 1'b0;
            lsu_memop     = 3'b010;
            mem_req_ready = mem_req_valid;
            mem_rsp_valid = mem_req_valid;
            mem_rdata     = 32'(c);
            #1;
            checkOutput($sformatf("alternate c%0d", c),
                        {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid},
                        {(c % 3 == 0) && c <= 9 && ((c / 3) % 2 == 0),
                         (c % 3 == 0) && c <= 9 && ((c / 3) % 2 == 1),
                         c == 2 || c == 8,
                         c == 5 || c == 11});
            @(posedge clk);
            @(negedge clk);
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;

        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset while waiting on memory: transaction abandoned, no response afterwards.
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h500;
        lsu_wen       = 1'b0;
        lsu_memop     = 3'b010;
        @(posedge clk);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_req_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        checkAllZero("reset_in_wait");
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            mem_rsp_valid = (c == 0);
            mem_rdata     = 32'hBAD0BAD0;
            #1;
            checkOutput($sformatf("after_reset c%0d", c),
                        {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid}, 3'b000);
            @(posedge clk);
            @(negedge clk);
        end
        mem_rsp_valid = 1'b0;
        model_last    = 1;

        // Randomized transactions against the reference model.
        for (int i = 0; i < 40; i++) begin
            rv.ifu_v = 1'($urandom);
            rv.lsu_v = 1'($urandom);
            if (!rv.ifu_v && !rv.lsu_v) rv.lsu_v = 1'b1;
            rv.ifu_a = $urandom;
            rv.lsu_a = $urandom;
            rv.wen   = 1'($urandom);
            rv.op    = ops[$urandom_range(0, 4)];
            rv.wdata = $urandom;
            rv.stall = $urandom_range(0, 3);
            rv.lat   = int'($urandom_range(0, 7)) - 1;
            rv.mdata = $urandom;
            rv = modelTxn(rv, model_last);
            applyStimulus($sformatf("rand%0d", i), rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
